// File: rtl/pc_1.sv
// 8-bit program counter driven by board buttons, displayed as two hex digits
// on a multiplexed, active-low four-digit seven-segment display.
module pc_1 #(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic       clock,
  input  logic       btnr,
  input  logic       btns,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       btnl,
  input  logic [7:0] new_count,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic [3:0] an
);

  logic [7:0]              pc;
  logic [REFRESH_BITS-1:0] refresh;
  logic [3:0]              nibble;
  logic [6:0]              font;
  logic [6:0]              seg;

  always_ff @(posedge clock or posedge btnr) begin
    if (btnr) begin
      pc <= '0;
    end else if (btns) begin
      if (btnl)      pc <= new_count;
      else if (btnu) pc <= pc + 8'd1;
      else if (btnd) pc <= pc - 8'd1;
    end
  end

  always_ff @(posedge clock or posedge btnr) begin
    if (btnr) refresh <= '0;
    else      refresh <= refresh + 1'b1;
  end

  always_comb begin
    nibble = refresh[REFRESH_BITS-1] ? pc[7:4] : pc[3:0];
    font   = 7'b1111111;
    case (nibble)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      4'hF: font = 7'b0111000;
      default: font = 7'b1111111;
    endcase
  end

  // Segments and anodes share one register stage so a digit change never
  // shows the wrong nibble for a cycle.
  always_ff @(posedge clock or posedge btnr) begin
    if (btnr) begin
      an  <= 4'b1110;
      seg <= 7'b0000001;
      dp  <= 1'b1;
    end else begin
      an  <= refresh[REFRESH_BITS-1] ? 4'b1101 : 4'b1110;
      seg <= font;
      dp  <= 1'b1;
    end
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_pc_1.sv
// Scoreboard bench for pc_1: the stimulus side models the PC and display with
// plain arithmetic and queues expected outputs; a monitor compares each cycle.
module tb_pc_1;
  localparam int RB = 4;
  localparam logic [11:0] RESET_DISP = 12'b1110_0000001_1;

  logic       clock = 1'b0;
  logic       btnr, btns, btnu, btnd, btnl;
  logic [7:0] new_count;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;

  pc_1 #(.REFRESH_BITS(RB)) dut (
    .clock(clock), .btnr(btnr), .btns(btns), .btnu(btnu), .btnd(btnd),
    .btnl(btnl), .new_count(new_count),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [11:0] expq[$];
  int mpc = 0;
  int cyc = 0;

  logic [6:0] font_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Digit k is shown during clock periods [8k', 8k'+8) of a 16-clock frame.
  function automatic logic [11:0] disp(int p, int cy);
    int digit;
    int nib;
    digit = (cy / (1 << (RB - 1))) % 2;
    nib   = (digit == 1) ? (p / 16) % 16 : p % 16;
    return {(digit == 1) ? 4'b1101 : 4'b1110, font_tab[nib], 1'b1};
  endfunction

  always @(negedge clock) begin
    logic [11:0] exp_v, act_v;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      act_v = {an, a, b, c, d, e, f, g, dp};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL display {an,abcdefg,dp}: got %b required %b at %0t", act_v, exp_v, $time);
      end
    end
  end

  task automatic step(input bit r, input bit s, input bit l, input bit u, input bit dn,
                      input logic [7:0] nc);
    @(negedge clock);
    #1;
    btnr = r; btns = s; btnl = l; btnu = u; btnd = dn; new_count = nc;
    @(posedge clock);
    if (r) begin
      expq.push_back(RESET_DISP);
      mpc = 0;
      cyc = 0;
    end else begin
      expq.push_back(disp(mpc, cyc));
      cyc++;
      if (s) begin
        if (l)       mpc = nc;
        else if (u)  mpc = (mpc + 1) % 256;
        else if (dn) mpc = (mpc + 255) % 256;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    btns = 1'b1; btnl = 1'b1; btnu = 1'b0; btnd = 1'b0; new_count = 8'd7;
    btnr = 1'b1;
    #1;
    checks++;
    if ({an, a, b, c, d, e, f, g, dp} !== RESET_DISP) begin
      failures++;
      $display("FAIL async_reset outputs: got %b required %b", {an, a, b, c, d, e, f, g, dp}, RESET_DISP);
    end
    mpc = 0;
    cyc = 0;
    step(1, 1, 1, 0, 0, 8'd7);
    step(1, 1, 1, 0, 0, 8'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    btnr = 1'b0; btns = 1'b0; btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; new_count = '0;
    do_reset();

    step(0, 1, 1, 0, 0, 8'h05);
    step(0, 1, 0, 0, 0, 8'h03);
    step(0, 1, 0, 1, 0, 8'h00);
    step(0, 1, 0, 1, 0, 8'h00);
    step(0, 1, 0, 0, 1, 8'h00);
    step(0, 1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 8'h00);

    step(0, 1, 1, 0, 0, 8'hFF);
    step(0, 1, 0, 1, 0, 8'h00);
    step(0, 1, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 8'h00);

    step(0, 1, 1, 1, 1, 8'h3C);
    step(0, 1, 0, 1, 1, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < 800; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           1'($urandom), 1'($urandom), 8'($urandom));

    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 8'h00);

    step(0, 1, 1, 0, 0, 8'hA7);
    for (int i = 0; i < 40; i++)
      step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));

    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom), $urandom_range(0, 15) == 0,
           1'($urandom), 1'($urandom), 8'($urandom));

    @(negedge clock);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
